// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access-size encodings and
// the alignment rule used both when accepting a request and when flagging Misalign.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Size 11 is never legal; halfwords need an even address, words a 4-byte one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Datapath request/response and data-memory signals of the LSU bundled in one
// interface; slave is the LSU view, master is the datapath-plus-memory view.
interface lsu_if;

    logic        Req;
    logic        WE;
    logic [1:0]  Size;
    logic        Signed;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        Done;
    logic        Busy;
    logic        Misalign;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemDataOut;
    logic [31:0] MemDataIn;

    modport slave (
        input  Req, WE, Size, Signed, Addr, WData, MemDataIn,
        output RData, Done, Busy, Misalign, MemRead, MemWrite, MemAddr, MemDataOut
    );

    modport master (
        output Req, WE, Size, Signed, Addr, WData, MemDataIn,
        input  RData, Done, Busy, Misalign, MemRead, MemWrite, MemAddr, MemDataOut
    );

endinterface

// File: rtl/lsu_align.sv
// Big-endian lane handling: extracts and extends a load lane from a memory word,
// and merges store data into a previously read word for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rword,
    input  logic [31:0] i_base,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane 00 is the most significant byte of the word.
    always_comb begin
        w_byte = 8'h00;
        case (i_lane)
            2'b00:   w_byte = i_rword[31:24];
            2'b01:   w_byte = i_rword[23:16];
            2'b10:   w_byte = i_rword[15:8];
            default: w_byte = i_rword[7:0];
        endcase
        if (i_lane[1]) begin
            w_half = i_rword[15:0];
        end else begin
            w_half = i_rword[31:16];
        end
    end

    // Load result: right-justified lane, sign- or zero-extended.
    always_comb begin
        o_load = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load = {{16{i_signed & w_half[15]}}, w_half};
            SZ_WORD: o_load = i_rword;
            default: o_load = 32'h0000_0000;
        endcase
    end

    // Store word: target lane of the read-back word replaced by store data.
    always_comb begin
        o_merge = i_base;
        case (i_size)
            SZ_BYTE: begin
                case (i_lane)
                    2'b00:   o_merge[31:24] = i_wdata[7:0];
                    2'b01:   o_merge[23:16] = i_wdata[7:0];
                    2'b10:   o_merge[15:8]  = i_wdata[7:0];
                    default: o_merge[7:0]   = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_lane[1]) begin
                    o_merge[15:0] = i_wdata[15:0];
                end else begin
                    o_merge[31:16] = i_wdata[15:0];
                end
            end
            SZ_WORD: o_merge = i_wdata;
            default: o_merge = i_base;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request in IDLE, performs a read, a write or a
// read-modify-write on a word-addressed data memory, then pulses Done.
module lsu
    import lsu_pkg::*;
(
    input  logic  Clock,
    input  logic  Resetn,
    lsu_if.slave  bus
);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rword;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_req_bad;
    logic        w_misalign;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign w_accept   = (r_state == ST_IDLE) && bus.Req;
    assign w_req_bad  = is_misaligned(bus.Size, bus.Addr[1:0]);
    assign w_misalign = is_misaligned(r_size, r_addr[1:0]);

    lsu_align u_align (
        .i_rword  (bus.MemDataIn),
        .i_base   (r_rword),
        .i_wdata  (r_wdata),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_lane   (r_addr[1:0]),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    // State register.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; sub-word stores go through RD to fetch the word to merge into.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.Req) begin
                    if (w_req_bad) begin
                        w_next = ST_DONE;
                    end else if (!bus.WE) begin
                        w_next = ST_RD;
                    end else if (bus.Size == SZ_WORD) begin
                        w_next = ST_WR;
                    end else begin
                        w_next = ST_RD;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RD: begin
                if (r_we) begin
                    w_next = ST_WR;
                end else begin
                    w_next = ST_DONE;
                end
            end
            ST_WR:   w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request latch and read-back word capture.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= 32'h0000_0000;
            r_wdata  <= 32'h0000_0000;
            r_rword  <= 32'h0000_0000;
        end else begin
            if (w_accept) begin
                r_we     <= bus.WE;
                r_size   <= bus.Size;
                r_signed <= bus.Signed;
                r_addr   <= bus.Addr;
                r_wdata  <= bus.WData;
            end
            if (r_state == ST_RD) begin
                r_rword <= bus.MemDataIn;
            end
        end
    end

    // Load result register: becomes visible exactly in the DONE cycle; stores leave it alone.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_rdata <= 32'h0000_0000;
        end else if ((r_state == ST_RD) && !r_we) begin
            r_rdata <= w_load;
        end else if (w_accept && w_req_bad) begin
            r_rdata <= 32'h0000_0000;
        end
    end

    // Output decode from the state register; MemWrite is also gated by Resetn
    // so a reset arriving in a WR cycle can never commit a write.
    always_comb begin
        bus.Busy       = (r_state != ST_IDLE);
        bus.Done       = (r_state == ST_DONE);
        bus.Misalign   = (r_state == ST_DONE) && w_misalign;
        bus.MemRead    = (r_state == ST_RD);
        bus.MemWrite   = (r_state == ST_WR) && Resetn;
        bus.MemAddr    = {r_addr[31:2], 2'b00};
        bus.RData      = r_rdata;
        if (r_state == ST_WR) begin
            bus.MemDataOut = w_merge;
        end else begin
            bus.MemDataOut = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized accesses checked
// against an arithmetic byte-lane model and a shadow copy of data memory.
module tb_lsu;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] exp_rdata = 32'h0;
    logic        pl_en     = 1'b0;
    logic [5:0]  pl_idx    = 6'd0;
    logic [31:0] pl_data   = 32'h0;

    lsu_if bus ();

    lsu dut (
        .Clock  (clk),
        .Resetn (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign bus.MemDataIn = mem[bus.MemAddr[7:2]];

    // Data memory: commits on the falling edge; preload port used only while idle.
    always @(negedge clk) begin
        if (bus.MemWrite) begin
            mem[bus.MemAddr[7:2]] <= bus.MemDataOut;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input logic [31:0] a);
        int          sh;
        logic [31:0] v;
        if (sz == 2'd0) begin
            sh = (3 - int'(a[1:0])) * 8;
            v  = (w >> sh) & 32'h0000_00FF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            sh = a[1] ? 0 : 16;
            v  = (w >> sh) & 32'h0000_FFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] st_model(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] sz, input logic [31:0] a);
        int          sh;
        logic [31:0] mask;
        if (sz == 2'd0) begin
            sh   = (3 - int'(a[1:0])) * 8;
            mask = 32'h0000_00FF << sh;
            return (old & ~mask) | ((wd << sh) & mask);
        end else if (sz == 2'd1) begin
            sh   = a[1] ? 0 : 16;
            mask = 32'h0000_FFFF << sh;
            return (old & ~mask) | ((wd << sh) & mask);
        end
        return wd;
    endfunction

    task automatic poke(input int idx, input logic [31:0] d);
        pl_idx  = idx[5:0];
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        #1;
        pl_en = 1'b0;
        ref_mem[idx] = d;
        @(posedge clk);
        #1;
    endtask

    // One complete access, entered and left at posedge+1 with the LSU idle.
    task automatic do_access(input logic we, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd, input bit hold_req);
        int          idx, lat, cyc, rd_cnt, wr_cnt, exp_rd, exp_wr;
        bit          mis, seen;
        logic [31:0] new_word;
        idx      = int'(a[7:2]);
        mis      = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        lat      = mis ? 1 : (!we ? 2 : (sz == 2'd2 ? 2 : 3));
        exp_rd   = (mis || (we && sz == 2'd2)) ? 0 : 1;
        exp_wr   = (we && !mis) ? 1 : 0;
        new_word = st_model(ref_mem[idx], wd, sz, a);
        if (mis)      exp_rdata = 32'h0;
        else if (!we) exp_rdata = ld_model(ref_mem[idx], sz, sg, a);
        bus.Req = 1'b1; bus.WE = we; bus.Size = sz; bus.Signed = sg; bus.Addr = a; bus.WData = wd;
        @(posedge clk);
        #1;
        bus.Req = 1'b0; bus.WE = $urandom_range(0, 1); bus.Size = 2'($urandom_range(0, 3));
        bus.Signed = $urandom_range(0, 1); bus.Addr = $urandom; bus.WData = $urandom;
        cyc = 1; seen = 0; rd_cnt = 0; wr_cnt = 0;
        while (!seen && cyc <= 8) begin
            chk("busy_active", 32'(bus.Busy), 32'd1);
            if (bus.MemRead) begin
                rd_cnt++;
                chk("rd_addr", bus.MemAddr, {a[31:2], 2'b00});
            end
            if (bus.MemWrite) begin
                wr_cnt++;
                chk("wr_addr", bus.MemAddr, {a[31:2], 2'b00});
                chk("wr_data", bus.MemDataOut, new_word);
            end else begin
                chk("dout_zero", bus.MemDataOut, 32'h0);
            end
            if (bus.Done) begin
                seen = 1;
                chk("latency", 32'(cyc), 32'(lat));
                chk("rdata", bus.RData, exp_rdata);
                chk("misalign", 32'(bus.Misalign), 32'(mis));
                if (hold_req) begin
                    bus.Req = 1'b1; bus.WE = 1'b0; bus.Size = 2'd2; bus.Addr = 32'h0;
                end
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("rd_count", 32'(rd_cnt), 32'(exp_rd));
        chk("wr_count", 32'(wr_cnt), 32'(exp_wr));
        if (exp_wr == 1) ref_mem[idx] = new_word;
        @(posedge clk);
        #1;
        bus.Req = 1'b0;
        chk("busy_after", 32'(bus.Busy), 32'd0);
        chk("done_after", 32'(bus.Done), 32'd0);
        chk("rdata_hold", bus.RData, exp_rdata);
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_done"}, 32'(bus.Done), 32'd0);
        chk({tag, "_busy"}, 32'(bus.Busy), 32'd0);
        chk({tag, "_mis"},  32'(bus.Misalign), 32'd0);
        chk({tag, "_mrd"},  32'(bus.MemRead), 32'd0);
        chk({tag, "_mwr"},  32'(bus.MemWrite), 32'd0);
        chk({tag, "_dout"}, bus.MemDataOut, 32'h0);
        chk({tag, "_maddr"}, bus.MemAddr, 32'h0);
        chk({tag, "_rdata"}, bus.RData, 32'h0);
    endtask

    initial begin
        bus.Req = 1'b0; bus.WE = 1'b0; bus.Size = 2'd0; bus.Signed = 1'b0;
        bus.Addr = 32'h0; bus.WData = 32'h0;
        rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_quiet("rst_low");
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk_quiet("rst_rel");

        for (int i = 0; i < 64; i++) poke(i, $urandom);

        // Directed cases from the feature list.
        poke(4, 32'hDEAD_BEEF);
        do_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        poke(4, 32'h12F4_5678);
        do_access(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0);
        chk("lb_value", exp_rdata, 32'hFFFF_FFF4);
        do_access(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0);
        chk("lbu_value", bus.RData, 32'h0000_00F4);
        poke(4, 32'h1122_3344);
        do_access(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AA, 1'b0);
        chk("sb_mem", mem[4], 32'h1122_33AA);
        do_access(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, 1'b1);
        do_access(1'b1, 2'd3, 1'b0, 32'h24, 32'h1234_5678, 1'b0);
        do_access(1'b1, 2'd1, 1'b0, 32'h2A, 32'h0000_BEEF, 1'b0);
        do_access(1'b0, 2'd1, 1'b1, 32'h2A, 32'h0, 1'b0);
        chk("lh_value", bus.RData, 32'hFFFF_BEEF);

        // Reset arriving in the WR cycle of a word store.
        bus.Req = 1'b1; bus.WE = 1'b1; bus.Size = 2'd2; bus.Addr = 32'h20; bus.WData = 32'h55AA_55AA;
        @(posedge clk);
        #1;
        bus.Req = 1'b0;
        chk("rst_wr_pre", 32'(bus.MemWrite), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_wr_gate", 32'(bus.MemWrite), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_rdata = 32'h0;
        chk_quiet("rst_mid");
        chk("rst_mem", mem[8], ref_mem[8]);
        @(posedge clk);
        #1;
        chk("rst_no_done", 32'(bus.Done), 32'd0);

        // Randomized accesses against the reference model.
        for (int n = 0; n < 60; n++) begin
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 255)), $urandom, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
